usr_shift_controller: RTL and testbench

//   Sequencer for the universal shift register (USR) datapath. Accepts one job per

---
 rtl/usr_shift_if.sv | 30 +++
 rtl/usr_shift_controller.sv | 122 ++++++++++++
 tb/tb_usr_shift_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/usr_shift_if.sv
// Requester/USR-pin bundle for the USR shift sequencer.
// The master side issues jobs; the slave side is the controller driving the USR pins.
interface usr_shift_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH) + 1
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] din;
  logic             dir;
  logic [CNTW-1:0]  count;
  logic             abort;
  logic             ser_in;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_pin;
  logic             usr_sir;
  logic             usr_sil;
  logic             busy;
  logic             done;

  modport master (
    output start, din, dir, count, abort, ser_in,
    input  ready, usr_mode, usr_pin, usr_sir, usr_sil, busy, done
  );

  modport slave (
    input  start, din, dir, count, abort, ser_in,
    output ready, usr_mode, usr_pin, usr_sir, usr_sil, busy, done
  );
endinterface

// File: rtl/usr_shift_controller.sv
// Sequencer for one universal shift register: load a word, shift it N places, then hold.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | ready for a job, USR held
//   S_LOAD  | one cycle of parallel load (mode 11)
//   S_SHIFT | one shift per cycle until remaining reaches zero
//   S_DONE  | one-cycle done pulse, USR held, not yet ready
module usr_shift_controller #(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  usr_shift_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(WIDTH);

  state_t           state;
  logic [CNTW-1:0]  remaining;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] pin_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CNTW-1:0]  count_clamped;

  assign count_clamped = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= MODE_HOLD;
      pin_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start outranks a simultaneous abort here
          if (bus.start) begin
            pin_q     <= bus.din;
            dir_q     <= bus.dir;
            remaining <= count_clamped;
            state     <= S_LOAD;
            mode_q    <= MODE_LOAD;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            state   <= S_IDLE;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (remaining != '0) begin
            state  <= S_SHIFT;
            mode_q <= dir_q ? MODE_SHL : MODE_SHR;
          end else begin
            state  <= S_DONE;
            mode_q <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          remaining <= remaining - 1'b1;
          if (bus.abort) begin
            state   <= S_IDLE;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (remaining == CNTW'(1)) begin
            state  <= S_DONE;
            mode_q <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          mode_q  <= MODE_HOLD;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.usr_mode = mode_q;
  assign bus.usr_pin  = pin_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  // Serial inputs follow ser_in only on the side currently shifting in
  assign bus.usr_sir  = (state == S_SHIFT) && !dir_q && bus.ser_in;
  assign bus.usr_sil  = (state == S_SHIFT) &&  dir_q && bus.ser_in;

endmodule

// File: tb/tb_usr_shift_controller.sv
// Scoreboard bench for usr_shift_controller: jobs push a per-cycle expected trace,
// a negedge monitor pops and compares whenever the controller is active.
module tb_usr_shift_controller;
  localparam int WIDTH = 4;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [3:0] pin;
    logic       sir;
    logic       sil;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] usr_q = 4'b0000;

  usr_shift_if #(.WIDTH(WIDTH)) bus();

  usr_shift_controller #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural USR driven by the controller pins
  always @(posedge clk) begin
    case (bus.usr_mode)
      2'b11: usr_q <= bus.usr_pin;
      2'b01: usr_q <= {bus.usr_sir, usr_q[3:1]};
      2'b10: usr_q <= {usr_q[2:0], bus.usr_sil};
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.busy || bus.done || bus.usr_mode != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc %0d mode %b done %b busy %b expected idle",
                 cyc, bus.usr_mode, bus.done, bus.busy);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.mode !== bus.usr_mode || mon_e.pin !== bus.usr_pin ||
            mon_e.sir !== bus.usr_sir || mon_e.sil !== bus.usr_sil ||
            mon_e.busy !== bus.busy || mon_e.done !== bus.done) begin
          errors++;
          $display("FAIL trace: got cyc %0d mode %b pin %b sir %b sil %b busy %b done %b expected cyc %0d mode %b pin %b sir %b sil %b busy %b done %b",
                   cyc, bus.usr_mode, bus.usr_pin, bus.usr_sir, bus.usr_sil, bus.busy, bus.done,
                   mon_e.cyc, mon_e.mode, mon_e.pin, mon_e.sir, mon_e.sil, mon_e.busy, mon_e.done);
        end
      end
    end
  end

  // Called at a negedge with the controller ready; returns at the negedge where ready is back.
  task automatic run_job(input logic [3:0] d, input logic dr, input logic [2:0] c,
                         input logic s, input int abort_sh, input int spurious_sh,
                         input logic abort_with_start);
    int   n;
    int   e0;
    int   last;
    exp_t e;
    n  = (c > 3'd4) ? 4 : int'(c);
    e0 = cyc;
    check("ready_before_start", bus.ready, 1'b1);
    bus.din    = d;
    bus.dir    = dr;
    bus.count  = c;
    bus.ser_in = s;
    bus.start  = 1'b1;
    bus.abort  = abort_with_start;
    e = '{cyc: e0 + 1, mode: 2'b11, pin: d, sir: 1'b0, sil: 1'b0, busy: 1'b1, done: 1'b0};
    exp_q.push_back(e);
    for (int i = 1; i <= n; i++) begin
      if (abort_sh != 0 && i > abort_sh) break;
      e = '{cyc: e0 + 1 + i, mode: (dr ? 2'b10 : 2'b01), pin: d,
            sir: (dr ? 1'b0 : s), sil: (dr ? s : 1'b0), busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
    end
    if (abort_sh == 0) begin
      e = '{cyc: e0 + n + 2, mode: 2'b00, pin: d, sir: 1'b0, sil: 1'b0, busy: 1'b0, done: 1'b1};
      exp_q.push_back(e);
    end
    last = (abort_sh != 0) ? abort_sh + 2 : n + 3;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (k == last) break;
      if (spurious_sh != 0 && k == spurious_sh + 1) bus.start = 1'b1;
      if (abort_sh != 0 && k == abort_sh + 1) bus.abort = 1'b1;
    end
    check("ready_after_job", bus.ready, 1'b1);
    check("busy_after_job", bus.busy, 1'b0);
    check("done_after_job", bus.done, 1'b0);
    check("mode_after_job", bus.usr_mode, 2'b00);
  endtask

  initial begin
    int e0;
    exp_t e;
    bus.start  = 1'b0;
    bus.din    = '0;
    bus.dir    = 1'b0;
    bus.count  = '0;
    bus.abort  = 1'b0;
    bus.ser_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mode", bus.usr_mode, 2'b00);
    check("rst_pin", bus.usr_pin, 4'b0000);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_job(4'b1011, 1'b0, 3'd2, 1'b1, 0, 0, 1'b0);
    check("usr_right2", usr_q, 4'b1110);
    @(negedge clk);
    run_job(4'b0011, 1'b1, 3'd3, 1'b0, 0, 0, 1'b0);
    check("usr_left3", usr_q, 4'b1000);
    @(negedge clk);
    run_job(4'b0110, 1'b0, 3'd0, 1'b1, 0, 0, 1'b0);
    check("usr_count0", usr_q, 4'b0110);
    @(negedge clk);
    run_job(4'b1001, 1'b1, 3'd7, 1'b1, 0, 0, 1'b0);
    check("usr_clamp", usr_q, 4'b1111);
    @(negedge clk);
    run_job(4'b1100, 1'b0, 3'd3, 1'b0, 0, 1, 1'b0);
    check("usr_spurious_start", usr_q, 4'b0001);
    @(negedge clk);
    run_job(4'b1010, 1'b1, 3'd4, 1'b1, 2, 0, 1'b0);
    check("usr_abort", usr_q, 4'b1011);
    @(negedge clk);
    run_job(4'b0101, 1'b0, 3'd1, 1'b1, 0, 0, 1'b0);
    check("usr_b2b_first", usr_q, 4'b1010);
    run_job(4'b0001, 1'b1, 3'd2, 1'b0, 0, 0, 1'b1);
    check("usr_b2b_second", usr_q, 4'b0100);
    @(negedge clk);

    // Reset held for two edges in the middle of a shift
    e0 = cyc;
    bus.din = 4'b0101; bus.dir = 1'b0; bus.count = 3'd4; bus.ser_in = 1'b1; bus.start = 1'b1;
    e = '{cyc: e0 + 1, mode: 2'b11, pin: 4'b0101, sir: 1'b0, sil: 1'b0, busy: 1'b1, done: 1'b0};
    exp_q.push_back(e);
    e = '{cyc: e0 + 2, mode: 2'b01, pin: 4'b0101, sir: 1'b1, sil: 1'b0, busy: 1'b1, done: 1'b0};
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mode", bus.usr_mode, 2'b00);
    check("midrst_ready", bus.ready, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pin", bus.usr_pin, 4'b0000);
    check("midrst_sir", bus.usr_sir, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
